// File: rtl/cdb_result_buffer_pkg.sv
// Shared types and constants for the buffered CDB output stage.
// Optional same-cycle bypass of an empty buffer is enabled by defining CDB_BUF_BYPASS_EN.
package cdb_result_buffer_pkg;

  localparam int XLEN          = 32;
  localparam int RRN_BITS      = 6;
  localparam int CDB_MAX_BUSES = 4;

  typedef struct packed {
    logic [XLEN-1:0]     result;
    logic [XLEN-1:0]     address;
    logic [RRN_BITS-1:0] rrn;
    logic                reg_write;
  } cdb_entry_t;

  localparam cdb_entry_t CDB_ENTRY_ZERO = '{
    result:    {XLEN{1'b0}},
    address:   {XLEN{1'b0}},
    rrn:       {RRN_BITS{1'b0}},
    reg_write: 1'b0
  };

  function automatic int unsigned cap_u32(input int unsigned value, input int unsigned limit);
    if (value < limit) begin
      cap_u32 = value;
    end else begin
      cap_u32 = limit;
    end
  endfunction

endpackage

// File: rtl/cdb_result_buffer_if.sv
// Execution-side handshake, arbiter request/grant and CDB bus signals of the result buffer.
// The bypass build (CDB_BUF_BYPASS_EN) uses the same signal set.
interface cdb_result_buffer_if #(
  parameter int DEPTH_BITS = 2,
  parameter int NUM_BUSES  = 2,
  parameter int XLEN       = cdb_result_buffer_pkg::XLEN,
  parameter int RRN_BITS   = cdb_result_buffer_pkg::RRN_BITS
);

  localparam int REQ_BITS = $clog2(NUM_BUSES + 1);

  logic                          i_flush;
  logic                          i_valid;
  logic                          o_ready;
  logic [XLEN-1:0]               i_result;
  logic [XLEN-1:0]               i_address;
  logic [RRN_BITS-1:0]           i_rrn;
  logic                          i_reg_write;
  logic [REQ_BITS-1:0]           o_req_count;
  logic                          o_get_bus;
  logic [NUM_BUSES-1:0]          i_bus_granted;
  logic [NUM_BUSES-1:0]          o_cdb_valid;
  logic [NUM_BUSES*XLEN-1:0]     o_cdb_result;
  logic [NUM_BUSES*XLEN-1:0]     o_cdb_address;
  logic [NUM_BUSES*RRN_BITS-1:0] o_cdb_rrn;
  logic [NUM_BUSES-1:0]          o_cdb_reg_write;
  logic [DEPTH_BITS:0]           o_count;
  logic                          o_full;

  modport slave (
    input  i_flush, i_valid, i_result, i_address, i_rrn, i_reg_write, i_bus_granted,
    output o_ready, o_req_count, o_get_bus, o_cdb_valid, o_cdb_result, o_cdb_address,
           o_cdb_rrn, o_cdb_reg_write, o_count, o_full
  );

  modport master (
    output i_flush, i_valid, i_result, i_address, i_rrn, i_reg_write, i_bus_granted,
    input  o_ready, o_req_count, o_get_bus, o_cdb_valid, o_cdb_result, o_cdb_address,
           o_cdb_rrn, o_cdb_reg_write, o_count, o_full
  );

endinterface

// File: rtl/cdb_result_buffer_fifo_multi_pop.sv
// Circular buffer of CDB entries: one push, up to NUM_BUSES pops per cycle, synchronous flush.
// Exposes the NUM_BUSES oldest entries so the caller can route them to buses.
module fifo_multi_pop
  import cdb_result_buffer_pkg::*;
#(
  parameter int DEPTH_BITS = 2,
  parameter int NUM_BUSES  = 2,
  localparam int POP_BITS  = $clog2(NUM_BUSES + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                push,
  input  cdb_entry_t          push_data,
  input  logic [POP_BITS-1:0] pop_count,
  output cdb_entry_t          peek [NUM_BUSES],
  output logic [DEPTH_BITS:0] count
);

  localparam int DEPTH = 1 << DEPTH_BITS;

  cdb_entry_t            mem_r [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr_r;
  logic [DEPTH_BITS-1:0] rd_ptr_r;
  logic [DEPTH_BITS:0]   count_r;

  // Entry storage, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers and occupancy; pointer arithmetic wraps modulo the power-of-two depth.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {DEPTH_BITS{1'b0}};
      rd_ptr_r <= {DEPTH_BITS{1'b0}};
      count_r  <= {(DEPTH_BITS + 1){1'b0}};
    end else if (flush) begin
      wr_ptr_r <= {DEPTH_BITS{1'b0}};
      rd_ptr_r <= {DEPTH_BITS{1'b0}};
      count_r  <= {(DEPTH_BITS + 1){1'b0}};
    end else begin
      wr_ptr_r <= wr_ptr_r + DEPTH_BITS'(push);
      rd_ptr_r <= rd_ptr_r + DEPTH_BITS'(pop_count);
      count_r  <= count_r + (DEPTH_BITS + 1)'(push) - (DEPTH_BITS + 1)'(pop_count);
    end
  end

  // Oldest-first view of the head of the queue.
  always_comb begin
    for (int k = 0; k < NUM_BUSES; k++) begin
      peek[k] = mem_r[rd_ptr_r + DEPTH_BITS'(k)];
    end
  end

  assign count = count_r;

endmodule

// File: rtl/cdb_result_buffer.sv
// Buffered multi-bus CDB output stage: queues results and drains them oldest-first onto granted buses.
// Defining CDB_BUF_BYPASS_EN lets an empty buffer broadcast the incoming result in the same cycle.
module cdb_result_buffer
  import cdb_result_buffer_pkg::*;
#(
  parameter int DEPTH_BITS = 2,
  parameter int NUM_BUSES  = 2,
  parameter int XLEN       = cdb_result_buffer_pkg::XLEN,
  parameter int RRN_BITS   = cdb_result_buffer_pkg::RRN_BITS
) (
  input logic                i_clock,
  input logic                i_reset,
  cdb_result_buffer_if.slave bus
);

  localparam int DEPTH    = 1 << DEPTH_BITS;
  localparam int REQ_BITS = $clog2(NUM_BUSES + 1);
  localparam int CNT_BITS = DEPTH_BITS + 1;

  cdb_entry_t                    in_entry_s;
  cdb_entry_t                    peek_s [NUM_BUSES];
  logic [CNT_BITS-1:0]           count_s;
  logic                          full_s;
  logic                          ready_s;
  logic                          push_s;
  logic                          bypass_s;
  logic [REQ_BITS-1:0]           req_s;
  logic [REQ_BITS-1:0]           drove_s;
  logic [REQ_BITS-1:0]           pops_s;
  logic [NUM_BUSES-1:0]          valid_s;
  logic [NUM_BUSES*XLEN-1:0]     result_s;
  logic [NUM_BUSES*XLEN-1:0]     address_s;
  logic [NUM_BUSES*RRN_BITS-1:0] rrn_s;
  logic [NUM_BUSES-1:0]          reg_write_s;

  assign in_entry_s = '{
    result:    bus.i_result,
    address:   bus.i_address,
    rrn:       bus.i_rrn,
    reg_write: bus.i_reg_write
  };

  fifo_multi_pop #(
    .DEPTH_BITS (DEPTH_BITS),
    .NUM_BUSES  (NUM_BUSES)
  ) u_fifo (
    .clk       (i_clock),
    .rst       (i_reset),
    .flush     (bus.i_flush),
    .push      (push_s),
    .push_data (in_entry_s),
    .pop_count (pops_s),
    .peek      (peek_s),
    .count     (count_s)
  );

  assign full_s = (count_s == CNT_BITS'(DEPTH));

  // Bus request size; a flush cycle requests nothing.
  always_comb begin
    bypass_s = 1'b0;
    req_s    = {REQ_BITS{1'b0}};
    if (bus.i_flush) begin
      req_s = {REQ_BITS{1'b0}};
    end else begin
`ifdef CDB_BUF_BYPASS_EN
      if (count_s == {CNT_BITS{1'b0}}) begin
        bypass_s = bus.i_valid;
        req_s    = REQ_BITS'(bus.i_valid);
      end else begin
        req_s = REQ_BITS'(cap_u32(32'(count_s), 32'(NUM_BUSES)));
      end
`else
      req_s = REQ_BITS'(cap_u32(32'(count_s), 32'(NUM_BUSES)));
`endif
    end
  end

  // The j-th set grant bit (ascending bus index) carries the j-th oldest requested entry.
  always_comb begin
    int         rank_s;
    cdb_entry_t pick_s;
    cdb_entry_t src_s;
    rank_s      = 32'sd0;
    pick_s      = CDB_ENTRY_ZERO;
    src_s       = CDB_ENTRY_ZERO;
    valid_s     = {NUM_BUSES{1'b0}};
    result_s    = {(NUM_BUSES * XLEN){1'b0}};
    address_s   = {(NUM_BUSES * XLEN){1'b0}};
    rrn_s       = {(NUM_BUSES * RRN_BITS){1'b0}};
    reg_write_s = {NUM_BUSES{1'b0}};
    for (int k = 0; k < NUM_BUSES; k++) begin
      pick_s = CDB_ENTRY_ZERO;
      for (int j = 0; j < NUM_BUSES; j++) begin
        pick_s = (j == rank_s) ? peek_s[j] : pick_s;
      end
      src_s = bypass_s ? in_entry_s : pick_s;
      if (bus.i_bus_granted[k] && (rank_s < int'(req_s))) begin
        valid_s[k]                       = 1'b1;
        result_s[k*XLEN +: XLEN]         = src_s.result;
        address_s[k*XLEN +: XLEN]        = src_s.address;
        rrn_s[k*RRN_BITS +: RRN_BITS]    = src_s.rrn;
        reg_write_s[k]                   = src_s.reg_write;
        rank_s                           = rank_s + 32'sd1;
      end else begin
        valid_s[k] = 1'b0;
      end
    end
    drove_s = REQ_BITS'(rank_s);
  end

  // Push/pop control; a result broadcast straight from the inputs never occupies an entry.
  always_comb begin
    ready_s = ~full_s & ~bus.i_flush;
    if (bypass_s && (drove_s != {REQ_BITS{1'b0}})) begin
      push_s = 1'b0;
      pops_s = {REQ_BITS{1'b0}};
    end else begin
      push_s = bus.i_valid & ready_s;
      pops_s = drove_s;
    end
  end

  assign bus.o_ready         = ready_s;
  assign bus.o_req_count     = req_s;
  assign bus.o_get_bus       = (req_s != {REQ_BITS{1'b0}});
  assign bus.o_cdb_valid     = valid_s;
  assign bus.o_cdb_result    = result_s;
  assign bus.o_cdb_address   = address_s;
  assign bus.o_cdb_rrn       = rrn_s;
  assign bus.o_cdb_reg_write = reg_write_s;
  assign bus.o_count         = count_s;
  assign bus.o_full          = full_s;

endmodule

// File: tb/tb_cdb_result_buffer.sv
// Self-checking bench for cdb_result_buffer: directed scenarios plus randomized traffic against a queue model.
// Expectations follow the CDB_BUF_BYPASS_EN setting of the build.
module tb_cdb_result_buffer;
  import cdb_result_buffer_pkg::*;

  localparam int DB    = 2;
  localparam int NB    = 2;
  localparam int DEPTH = 1 << DB;
  localparam int XL    = XLEN;
  localparam int RB    = RRN_BITS;

  logic       clk;
  logic       rst;
  int         errors;
  int         checks;
  cdb_entry_t mq[$];
  cdb_entry_t zero_e;

  cdb_result_buffer_if #(.DEPTH_BITS(DB), .NUM_BUSES(NB), .XLEN(XL), .RRN_BITS(RB)) bus_if ();

  cdb_result_buffer #(.DEPTH_BITS(DB), .NUM_BUSES(NB), .XLEN(XL), .RRN_BITS(RB)) dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic cdb_entry_t mk(input logic [XL-1:0] r, input logic [XL-1:0] a,
                                    input logic [RB-1:0] n, input logic w);
    cdb_entry_t e;
    e.result = r; e.address = a; e.rrn = n; e.reg_write = w;
    return e;
  endfunction

  task automatic drive(input logic v, input cdb_entry_t e, input logic [NB-1:0] g, input logic f);
    bus_if.i_valid       = v;
    bus_if.i_result      = e.result;
    bus_if.i_address     = e.address;
    bus_if.i_rrn         = e.rrn;
    bus_if.i_reg_write   = e.reg_write;
    bus_if.i_bus_granted = g;
    bus_if.i_flush       = f;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    drive(1'b0, zero_e, 2'b00, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    mq.delete();
  endtask

  task automatic push_one(input cdb_entry_t e);
    drive(1'b1, e, 2'b00, 1'b0);
    tick();
    drive(1'b0, zero_e, 2'b00, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, zero_e, 2'b00, 1'b0);
    #3;
    checks++; if (bus_if.o_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus_if.o_count); end
    checks++; if (bus_if.o_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %0b want 0", bus_if.o_full); end
    checks++; if (bus_if.o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b want 1", bus_if.o_ready); end
    checks++; if (bus_if.o_get_bus !== 1'b0) begin errors++; $display("FAIL reset_get_bus: got %0b want 0", bus_if.o_get_bus); end
    checks++; if (bus_if.o_req_count !== 2'd0) begin errors++; $display("FAIL reset_req: got %0d want 0", bus_if.o_req_count); end
    checks++; if (bus_if.o_cdb_valid !== 2'b00) begin errors++; $display("FAIL reset_valid: got %b want 00", bus_if.o_cdb_valid); end
    checks++; if (bus_if.o_cdb_result !== 64'd0) begin errors++; $display("FAIL reset_result: got %0h want 0", bus_if.o_cdb_result); end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_single();
    cdb_entry_t e;
    apply_reset();
    e = mk(32'hDEAD_BEEF, 32'h0000_1000, 6'd5, 1'b1);
    drive(1'b1, e, 2'b00, 1'b0); #2;
    checks++; if (bus_if.o_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %0b want 1", bus_if.o_ready); end
`ifdef CDB_BUF_BYPASS_EN
    checks++; if (bus_if.o_req_count !== 2'd1) begin errors++; $display("FAIL single_req0: got %0d want 1", bus_if.o_req_count); end
`else
    checks++; if (bus_if.o_req_count !== 2'd0) begin errors++; $display("FAIL single_req0: got %0d want 0", bus_if.o_req_count); end
`endif
    tick();
    drive(1'b0, zero_e, 2'b00, 1'b0); #2;
    checks++; if (bus_if.o_req_count !== 2'd1) begin errors++; $display("FAIL single_req1: got %0d want 1", bus_if.o_req_count); end
    checks++; if (bus_if.o_get_bus !== 1'b1) begin errors++; $display("FAIL single_get_bus: got %0b want 1", bus_if.o_get_bus); end
    drive(1'b0, zero_e, 2'b10, 1'b0); #2;
    checks++; if (bus_if.o_cdb_valid !== 2'b10) begin errors++; $display("FAIL single_valid: got %b want 10", bus_if.o_cdb_valid); end
    checks++; if (bus_if.o_cdb_rrn[RB +: RB] !== 6'd5) begin errors++; $display("FAIL single_rrn1: got %0d want 5", bus_if.o_cdb_rrn[RB +: RB]); end
    checks++; if (bus_if.o_cdb_result[XL +: XL] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_result1: got %0h want deadbeef", bus_if.o_cdb_result[XL +: XL]); end
    checks++; if (bus_if.o_cdb_result[0 +: XL] !== 32'd0) begin errors++; $display("FAIL single_result0: got %0h want 0", bus_if.o_cdb_result[0 +: XL]); end
    tick();
    drive(1'b0, zero_e, 2'b00, 1'b0); #2;
    checks++; if (bus_if.o_count !== 3'd0) begin errors++; $display("FAIL single_empty: got %0d want 0", bus_if.o_count); end
  endtask

  task automatic test_full();
    cdb_entry_t e [5];
    apply_reset();
    for (int i = 0; i < 5; i++) e[i] = mk(32'hA000_0000 + 32'(i), 32'h100 + 32'(i), 6'(i + 1), 1'b1);
    for (int i = 0; i < 4; i++) push_one(e[i]);
    #2;
    checks++; if (bus_if.o_count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d want 4", bus_if.o_count); end
    checks++; if (bus_if.o_full !== 1'b1) begin errors++; $display("FAIL full_flag: got %0b want 1", bus_if.o_full); end
    checks++; if (bus_if.o_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %0b want 0", bus_if.o_ready); end
    push_one(e[4]); #2;
    checks++; if (bus_if.o_count !== 3'd4) begin errors++; $display("FAIL full_no_store: got %0d want 4", bus_if.o_count); end
    drive(1'b1, e[4], 2'b01, 1'b0); #2;
    checks++; if (bus_if.o_cdb_result[0 +: XL] !== e[0].result) begin errors++; $display("FAIL full_pop_bus0: got %0h want %0h", bus_if.o_cdb_result[0 +: XL], e[0].result); end
    tick(); #2;
    checks++; if (bus_if.o_count !== 3'd3) begin errors++; $display("FAIL full_pop_no_admit: got %0d want 3", bus_if.o_count); end
    drive(1'b0, zero_e, 2'b11, 1'b0); tick();
    drive(1'b0, zero_e, 2'b01, 1'b0); #2;
    checks++; if (bus_if.o_cdb_result[0 +: XL] !== e[3].result) begin errors++; $display("FAIL full_last: got %0h want %0h", bus_if.o_cdb_result[0 +: XL], e[3].result); end
    tick(); #2;
    checks++; if (bus_if.o_count !== 3'd0) begin errors++; $display("FAIL full_drained: got %0d want 0", bus_if.o_count); end
  endtask

  task automatic test_multi_pop();
    cdb_entry_t a, b, c;
    apply_reset();
    a = mk(32'h0000_00AA, 32'h10, 6'd1, 1'b1);
    b = mk(32'h0000_00BB, 32'h14, 6'd2, 1'b0);
    c = mk(32'h0000_00CC, 32'h18, 6'd3, 1'b1);
    push_one(a); push_one(b); push_one(c);
    drive(1'b0, zero_e, 2'b11, 1'b0); #2;
    checks++; if (bus_if.o_cdb_result !== {b.result, a.result}) begin errors++; $display("FAIL mpop_ab: got %0h want %0h", bus_if.o_cdb_result, {b.result, a.result}); end
    checks++; if (bus_if.o_cdb_reg_write !== 2'b01) begin errors++; $display("FAIL mpop_rw: got %b want 01", bus_if.o_cdb_reg_write); end
    tick(); #2;
    checks++; if (bus_if.o_count !== 3'd1) begin errors++; $display("FAIL mpop_count: got %0d want 1", bus_if.o_count); end
    drive(1'b0, zero_e, 2'b01, 1'b0); #2;
    checks++; if (bus_if.o_cdb_address[0 +: XL] !== c.address) begin errors++; $display("FAIL mpop_c: got %0h want %0h", bus_if.o_cdb_address[0 +: XL], c.address); end
    tick();
  endtask

  task automatic test_wrap();
    cdb_entry_t p [6];
    apply_reset();
    for (int i = 0; i < 6; i++) p[i] = mk(32'hC000_0000 + 32'(i), 32'h200 + 32'(i), 6'(i + 10), 1'b1);
    for (int i = 0; i < 4; i++) push_one(p[i]);
    drive(1'b0, zero_e, 2'b11, 1'b0); tick();
    push_one(p[4]);
    drive(1'b1, p[5], 2'b11, 1'b0); #2;
    checks++; if (bus_if.o_cdb_result !== {p[3].result, p[2].result}) begin errors++; $display("FAIL wrap_pop: got %0h want %0h", bus_if.o_cdb_result, {p[3].result, p[2].result}); end
    tick(); #2;
    checks++; if (bus_if.o_count !== 3'd2) begin errors++; $display("FAIL wrap_count: got %0d want 2", bus_if.o_count); end
    drive(1'b0, zero_e, 2'b11, 1'b0); #2;
    checks++; if (bus_if.o_cdb_rrn !== {p[5].rrn, p[4].rrn}) begin errors++; $display("FAIL wrap_order: got %0h want %0h", bus_if.o_cdb_rrn, {p[5].rrn, p[4].rrn}); end
    tick();
  endtask

  task automatic test_flush();
    apply_reset();
    for (int i = 0; i < 3; i++) push_one(mk(32'hF0 + 32'(i), 32'h300, 6'd7, 1'b1));
    drive(1'b1, mk(32'h55, 32'h55, 6'd9, 1'b1), 2'b11, 1'b1); #2;
    checks++; if (bus_if.o_cdb_valid !== 2'b00) begin errors++; $display("FAIL flush_valid: got %b want 00", bus_if.o_cdb_valid); end
    checks++; if (bus_if.o_get_bus !== 1'b0) begin errors++; $display("FAIL flush_get_bus: got %0b want 0", bus_if.o_get_bus); end
    checks++; if (bus_if.o_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %0b want 0", bus_if.o_ready); end
    tick();
    drive(1'b0, zero_e, 2'b11, 1'b0); #2;
    checks++; if (bus_if.o_count !== 3'd0) begin errors++; $display("FAIL flush_count: got %0d want 0", bus_if.o_count); end
    checks++; if (bus_if.o_cdb_valid !== 2'b00) begin errors++; $display("FAIL flush_after: got %b want 00", bus_if.o_cdb_valid); end
    tick();
  endtask

  task automatic test_bypass();
    apply_reset();
    drive(1'b1, mk(32'h0000_1234, 32'h400, 6'd3, 1'b1), 2'b01, 1'b0); #2;
`ifdef CDB_BUF_BYPASS_EN
    checks++; if (bus_if.o_cdb_valid !== 2'b01) begin errors++; $display("FAIL bypass_valid: got %b want 01", bus_if.o_cdb_valid); end
    checks++; if (bus_if.o_cdb_result[0 +: XL] !== 32'h0000_1234) begin errors++; $display("FAIL bypass_data: got %0h want 1234", bus_if.o_cdb_result[0 +: XL]); end
    tick();
    drive(1'b0, zero_e, 2'b00, 1'b0); #2;
    checks++; if (bus_if.o_count !== 3'd0) begin errors++; $display("FAIL bypass_count: got %0d want 0", bus_if.o_count); end
`else
    checks++; if (bus_if.o_cdb_valid !== 2'b00) begin errors++; $display("FAIL nobypass_valid: got %b want 00", bus_if.o_cdb_valid); end
    tick();
    drive(1'b0, zero_e, 2'b01, 1'b0); #2;
    checks++; if (bus_if.o_cdb_result[0 +: XL] !== 32'h0000_1234) begin errors++; $display("FAIL nobypass_late: got %0h want 1234", bus_if.o_cdb_result[0 +: XL]); end
    tick(); #2;
    checks++; if (bus_if.o_count !== 3'd0) begin errors++; $display("FAIL nobypass_count: got %0d want 0", bus_if.o_count); end
`endif
  endtask

  task automatic test_reset_mid_drain();
    apply_reset();
    push_one(mk(32'h77, 32'h500, 6'd1, 1'b1));
    push_one(mk(32'h88, 32'h504, 6'd2, 1'b1));
    drive(1'b0, zero_e, 2'b11, 1'b0); #2;
    checks++; if (bus_if.o_cdb_valid !== 2'b11) begin errors++; $display("FAIL drain_valid: got %b want 11", bus_if.o_cdb_valid); end
    rst = 1'b1; #1;
    checks++; if (bus_if.o_cdb_valid !== 2'b00) begin errors++; $display("FAIL async_rst_valid: got %b want 00", bus_if.o_cdb_valid); end
    checks++; if (bus_if.o_cdb_result !== 64'd0) begin errors++; $display("FAIL async_rst_data: got %0h want 0", bus_if.o_cdb_result); end
    checks++; if (bus_if.o_count !== 3'd0) begin errors++; $display("FAIL async_rst_count: got %0d want 0", bus_if.o_count); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_random();
    cdb_entry_t              e, src;
    logic                    v, f, took;
    logic [NB-1:0]           g, evalid, erw;
    logic [NB*XL-1:0]        eres, eadr;
    logic [NB*RB-1:0]        errn;
    int                      n, j, ereq;
    apply_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      v = ($urandom_range(0, 3) != 0);
      e = mk($urandom, $urandom, RB'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
      g[0] = ($urandom_range(0, 2) == 0);
      g[1] = ($urandom_range(0, 2) == 0);
      f = ($urandom_range(0, 39) == 0);
      drive(v, e, g, f); #2;
      n = mq.size();
      ereq = f ? 0 : ((n < NB) ? n : NB);
`ifdef CDB_BUF_BYPASS_EN
      if (!f && n == 0) ereq = v ? 1 : 0;
`endif
      j = 0; evalid = '0; erw = '0; eres = '0; eadr = '0; errn = '0;
      for (int k = 0; k < NB; k++) begin
        if (g[k] && j < ereq) begin
          src = (n == 0) ? e : mq[j];
          evalid[k] = 1'b1; erw[k] = src.reg_write;
          eres[k*XL +: XL] = src.result; eadr[k*XL +: XL] = src.address; errn[k*RB +: RB] = src.rrn;
          j++;
        end
      end
      checks++; if (bus_if.o_cdb_valid !== evalid) begin errors++; $display("FAIL rnd_valid c%0d: got %b want %b", cyc, bus_if.o_cdb_valid, evalid); end
      checks++; if (bus_if.o_cdb_result !== eres) begin errors++; $display("FAIL rnd_result c%0d: got %0h want %0h", cyc, bus_if.o_cdb_result, eres); end
      checks++; if (bus_if.o_cdb_address !== eadr) begin errors++; $display("FAIL rnd_address c%0d: got %0h want %0h", cyc, bus_if.o_cdb_address, eadr); end
      checks++; if (bus_if.o_cdb_rrn !== errn || bus_if.o_cdb_reg_write !== erw) begin errors++; $display("FAIL rnd_rrn_rw c%0d: got %0h/%b want %0h/%b", cyc, bus_if.o_cdb_rrn, bus_if.o_cdb_reg_write, errn, erw); end
      checks++; if (bus_if.o_req_count !== 2'(ereq) || bus_if.o_get_bus !== (ereq != 0)) begin errors++; $display("FAIL rnd_req c%0d: got %0d/%0b want %0d", cyc, bus_if.o_req_count, bus_if.o_get_bus, ereq); end
      checks++; if (bus_if.o_ready !== (!f && n < DEPTH)) begin errors++; $display("FAIL rnd_ready c%0d: got %0b want %0b", cyc, bus_if.o_ready, (!f && n < DEPTH)); end
      checks++; if (bus_if.o_count !== 3'(n) || bus_if.o_full !== (n == DEPTH)) begin errors++; $display("FAIL rnd_count c%0d: got %0d/%0b want %0d", cyc, bus_if.o_count, bus_if.o_full, n); end
      tick();
      if (f) begin
        mq.delete();
      end else begin
        took = (n == 0) && (j != 0);
        if (!took) repeat (j) void'(mq.pop_front());
        if (v && n < DEPTH && !took) mq.push_back(e);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    zero_e = mk(32'd0, 32'd0, 6'd0, 1'b0);
    test_reset();
    test_single();
    test_full();
    test_multi_pop();
    test_wrap();
    test_flush();
    test_bypass();
    test_reset_mid_drain();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cdb_result_buffer.md
Name: cdb_result_buffer

Overview:
- Buffered multi-bus CDB output stage for execution combos (ALU, MUL, LSU).
- Sits between an execution unit's result feed and NUM_BUSES common data buses.
- Queues completed results in a FIFO and requests up to NUM_BUSES buses per cycle from the CDB arbiter. It drains oldest-first onto granted buses, so the unit is not stalled while waiting for a grant.

Parameters:
- DEPTH_BITS, 2, FIFO depth = 2**DEPTH_BITS entries (1..5).
- NUM_BUSES, 2, number of CDB channels driven (1..4).
- XLEN, 32, result/address width.
- RRN_BITS, 6, renamed register number width.

Ports:
- i_clock  in  1  clock, rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_flush  in  1  synchronous flush on misprediction; discards all entries.
- i_valid  in  1  execution unit presents a result.
- o_ready  out  1  buffer accepts a result this cycle.
- i_result  in  XLEN  result value.
- i_address  in  XLEN  instruction address (ROB lookup).
- i_rrn  in  RRN_BITS  destination renamed register.
- i_reg_write  in  1  result writes the register file.
- o_req_count  out  $clog2(NUM_BUSES+1)  number of buses requested.
- o_get_bus  out  1  o_req_count != 0.
- i_bus_granted  in  NUM_BUSES  per-bus grant from the arbiter, same cycle.
- o_cdb_valid  out  NUM_BUSES  bus k is driven this cycle (top level converts to 'z when low).
- o_cdb_result  out  NUM_BUSES*XLEN  per-bus result.
- o_cdb_address  out  NUM_BUSES*XLEN  per-bus address.
- o_cdb_rrn  out  NUM_BUSES*RRN_BITS  per-bus rrn.
- o_cdb_reg_write  out  NUM_BUSES  per-bus reg_write.
- o_count  out  DEPTH_BITS+1  current occupancy.
- o_full  out  1  o_count == 2**DEPTH_BITS.

Behaviour:
- Reset (asynchronous, active-high): pointers and count go to 0, and the following are all 0: o_full, o_get_bus, o_req_count, o_cdb_valid, o_cdb_*.
- o_ready is high at reset.
- Push handshake:
  - Entry is written when i_valid & o_ready.
  - o_ready = !o_full, computed from registered count only (no pop-through).
- Request: o_req_count = min(o_count, NUM_BUSES), combinational from registered state.
- Grant mapping:
  - The j-th set bit of i_bus_granted, in ascending bus index, drives the j-th oldest entry.
  - Grants beyond o_req_count are ignored, and that bus's o_cdb_valid stays 0.
  - Pops = min(popcount(i_bus_granted), o_req_count), applied at the clock edge.
- Data on a non-driven bus is 0.
- Latency: a result pushed in cycle N is requestable in cycle N+1.
- Push and pop in the same cycle: count' = count + push - pops. The read pointer wraps modulo depth.
- Full: i_valid is held by the unit and no write occurs. A pop in the same cycle does not admit the push.
- Empty: o_get_bus = 0 and no bus is driven.
- Flush:
  - In the i_flush cycle o_cdb_valid = 0, o_get_bus = 0 and o_ready = 0.
  - Next state is empty. Any push or grant in that cycle is discarded.
- Reset asserted mid-drain: outputs clear immediately (asynchronous). No partial bus drive survives.

Optional Feature:
- CDB_BUF_BYPASS_EN defined:
  - When o_count == 0, o_req_count = i_valid (capped at 1) and bus 0..N data comes from the inputs combinationally.
  - If granted, the result is broadcast the same cycle and not written to the FIFO; if not granted, it is pushed normally.
  - No bypass during i_flush.
- Undefined: minimum latency is 1 cycle, and there is no combinational path from i_valid or i_result to the CDB outputs.

Decomposition:
- pkg_defines gains:
  - typedef cdb_entry_t, a packed struct {result, address, rrn, reg_write}.
  - localparam CDB_MAX_BUSES = 4.
  - Reuses XLEN and RRN_BITS.
- Natural sub-module: fifo_multi_pop. It is a circular buffer of cdb_entry_t with 1 push, up to NUM_BUSES pops per cycle and a flush input. The grant-to-entry mapping and request logic stay in cdb_result_buffer.

Test Plan:
- Reset, then push result 0xDEAD_BEEF with rrn 5. Next cycle: o_req_count = 1. Grant bus 1 only: o_cdb_valid = 2'b10, o_cdb_rrn[1] = 5, and the buffer is empty after the edge.
- DEPTH_BITS = 2, push 4 entries with no grants: o_full = 1, o_ready = 0. A fifth i_valid is not stored, and o_count stays 4.
- 3 entries (A, B, C), grants 2'b11: bus0 = A, bus1 = B, o_count becomes 1. Next cycle, grant 2'b01: bus0 = C.
- Simultaneous push D with 2 pops from count 3: o_count becomes 2. Order C then D is preserved across pointer wrap.
- Flush with 3 entries plus a concurrent push and grant: o_cdb_valid = 0 that cycle, o_count = 0 next cycle, and nothing is broadcast afterward.
- CDB_BUF_BYPASS_EN, empty buffer: i_valid with result 0x1234 and grant 2'b01 in the same cycle gives bus0 = 0x1234 that cycle and o_count stays 0. Without the macro, the broadcast occurs 1 cycle later.
